// File: rtl/spi_rf_pkg.sv
// Shared constants for the CoreSPI APB register file: register addresses and
// interrupt bit positions.
package spi_rf_pkg;

  localparam logic [6:0] ADDR_CTRL1      = 7'h00;
  localparam logic [6:0] ADDR_INTCLR_LO  = 7'h04;
  localparam logic [6:0] ADDR_INTMASK_LO = 7'h10;
  localparam logic [6:0] ADDR_INTRAW_LO  = 7'h14;
  localparam logic [6:0] ADDR_CTRL2      = 7'h18;
  localparam logic [6:0] ADDR_CMD        = 7'h1C;
  localparam logic [6:0] ADDR_STATUS     = 7'h20;
  localparam logic [6:0] ADDR_SSEL       = 7'h24;
  localparam logic [6:0] ADDR_TXLVL      = 7'h28;
  localparam logic [6:0] ADDR_RXLVL      = 7'h2C;
  localparam logic [6:0] ADDR_TXWM       = 7'h30;
  localparam logic [6:0] ADDR_RXWM       = 7'h34;
  localparam logic [6:0] ADDR_INTCLR_HI  = 7'h38;
  localparam logic [6:0] ADDR_INTMASK_HI = 7'h3C;
  localparam logic [6:0] ADDR_INTRAW_HI  = 7'h40;
  localparam logic [6:0] ADDR_INTEN_HI   = 7'h44;
  localparam logic [6:0] ADDR_FRMCNT_LO  = 7'h48;
  localparam logic [6:0] ADDR_FRMCNT_HI  = 7'h4C;

  localparam int unsigned INT_W = 11;

  localparam int unsigned INT_TXDONE  = 0;
  localparam int unsigned INT_RXDONE  = 1;
  localparam int unsigned INT_RXOVF   = 2;
  localparam int unsigned INT_TXUNF   = 3;
  localparam int unsigned INT_CMDSIZE = 4;
  localparam int unsigned INT_PKTEND  = 5;
  localparam int unsigned INT_RXNE    = 6;
  localparam int unsigned INT_TXNF    = 7;
  localparam int unsigned INT_TXWM    = 8;
  localparam int unsigned INT_RXWM    = 9;
  localparam int unsigned INT_FRMDONE = 10;

endpackage

// File: rtl/spi_rf_ext_if.sv
// APB slave bus bundle for the SPI register file.
interface spi_rf_ext_if #(
  parameter int unsigned APB_DWIDTH = 8
);
  logic [6:0]            paddr;
  logic                  psel;
  logic                  pwrite;
  logic                  penable;
  logic [APB_DWIDTH-1:0] pwdata;
  logic [APB_DWIDTH-1:0] prdata;

  modport master (output paddr, psel, pwrite, penable, pwdata, input prdata);
  modport slave  (input paddr, psel, pwrite, penable, pwdata, output prdata);
endinterface

// File: rtl/spi_rf_lvlcnt.sv
// Saturating FIFO occupancy counter; clr wins over a same-cycle push/pop.
module spi_rf_lvlcnt #(
  parameter  int unsigned FIFO_DEPTH = 32,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (clr) begin
      level_d = '0;
    end else if (inc && !dec && level_q != LVL_MAX) begin
      level_d = level_q + LVL_W'(1);
    end else if (dec && !inc && level_q != '0) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign level = level_q;

endmodule

// File: rtl/spi_rf_ext.sv
// APB register file for the CoreSPI datapath: configuration, interrupt bank, FIFO levels.
// Define SPI_RF_FRAMECNT_EN to add the frame counter (0x48/0x4C) and raw interrupt bit 10.
module spi_rf_ext
  import spi_rf_pkg::*;
#(
  parameter  int unsigned APB_DWIDTH = 8,
  parameter  int unsigned NUM_SSEL   = 8,
  parameter  int unsigned FIFO_DEPTH = 32,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                pclk,
  input  logic                preset,
  spi_rf_ext_if.slave         apb,
  output logic                interrupt,
  input  logic                tx_done,
  input  logic                rx_done,
  input  logic                rx_channel_overflow,
  input  logic                tx_channel_underflow,
  input  logic                rx_cmdsize,
  input  logic                rx_pktend,
  input  logic                tx_fifo_write,
  input  logic                tx_fifo_read,
  input  logic                rx_fifo_write,
  input  logic                rx_fifo_read,
  input  logic                tx_fifo_full,
  input  logic                rx_fifo_empty,
  input  logic                ssel,
  input  logic                active,
  input  logic                first_frame,
  output logic                cfg_enable,
  output logic                cfg_master,
  output logic                cfg_frameurun,
  output logic                cfg_oenoff,
  output logic [2:0]          cfg_cmdsize,
  output logic [NUM_SSEL-1:0] cfg_ssel,
  output logic                clr_txfifo,
  output logic                clr_rxfifo,
  output logic [LVL_W-1:0]    tx_level,
  output logic [LVL_W-1:0]    rx_level
);

  logic             wr_en, rd_en;
  logic [7:0]       wdata, rdata;
  logic             unused_pwdata;

  logic [7:0]          ctrl1_q, ctrl1_d;
  logic [2:0]          cmdsize_q, cmdsize_d;
  logic [3:0]          en_lo_q, en_lo_d;
  logic [2:0]          en_hi_q, en_hi_d;
  logic [NUM_SSEL-1:0] ssel_q, ssel_d;
  logic [7:0]          txwm_q, txwm_d, rxwm_q, rxwm_d;
  logic                clr_tx_q, clr_tx_d, clr_rx_q, clr_rx_d;
  logic                txwm_cond, rxwm_cond, txwm_cond_q, rxwm_cond_q;
  logic [INT_W-1:0]    raw_q, raw_d, int_set, int_clr, int_en, int_masked;
  logic                frm_done;
`ifdef SPI_RF_FRAMECNT_EN
  logic [7:0]          frm_shadow_q, frm_shadow_d;
  logic [15:0]         frm_cnt_q, frm_cnt_d;
`endif

  assign wr_en         = apb.psel & apb.pwrite & apb.penable;
  assign rd_en         = apb.psel & apb.penable;
  assign wdata         = apb.pwdata[7:0];
  assign unused_pwdata = ^apb.pwdata;

  // Watermark conditions compared at a common 9-bit width (levels reach 256).
  assign txwm_cond = 9'(tx_level) <= 9'(txwm_q);
  assign rxwm_cond = 9'(rx_level) >= 9'(rxwm_q);

  always_comb begin
    ctrl1_d   = ctrl1_q;
    cmdsize_d = cmdsize_q;
    en_lo_d   = en_lo_q;
    en_hi_d   = en_hi_q;
    ssel_d    = ssel_q;
    txwm_d    = txwm_q;
    rxwm_d    = rxwm_q;
    clr_tx_d  = 1'b0;
    clr_rx_d  = 1'b0;
    int_clr   = '0;
    frm_done  = 1'b0;
`ifdef SPI_RF_FRAMECNT_EN
    frm_shadow_d = frm_shadow_q;
    frm_cnt_d    = frm_cnt_q;
`endif
    if (wr_en) begin
      case (apb.paddr)
        ADDR_CTRL1:     ctrl1_d = wdata & 8'hFB;
        ADDR_CTRL2:     begin cmdsize_d = wdata[2:0]; en_lo_d = wdata[7:4]; end
        ADDR_CMD:       begin clr_rx_d = wdata[0]; clr_tx_d = wdata[1]; end
        ADDR_SSEL:      ssel_d = wdata[NUM_SSEL-1:0];
        ADDR_TXWM:      txwm_d = wdata;
        ADDR_RXWM:      rxwm_d = wdata;
        ADDR_INTEN_HI:  en_hi_d = wdata[2:0];
        ADDR_INTCLR_LO: int_clr[7:0] = wdata;
        ADDR_INTCLR_HI: int_clr[10:8] = wdata[2:0];
`ifdef SPI_RF_FRAMECNT_EN
        ADDR_FRMCNT_LO: frm_shadow_d = wdata;
`endif
        default: ;
      endcase
    end
`ifdef SPI_RF_FRAMECNT_EN
    // A CPU load takes precedence over a same-cycle tx_done decrement.
    if (wr_en && apb.paddr == ADDR_FRMCNT_HI) begin
      frm_cnt_d = {wdata, frm_shadow_q};
    end else if (tx_done && frm_cnt_q != 16'd0) begin
      frm_cnt_d = frm_cnt_q - 16'd1;
      frm_done  = (frm_cnt_q == 16'd1);
    end
`endif
    int_set              = '0;
    int_set[INT_TXDONE]  = tx_done;
    int_set[INT_RXDONE]  = rx_done;
    int_set[INT_RXOVF]   = rx_channel_overflow;
    int_set[INT_TXUNF]   = tx_channel_underflow;
    int_set[INT_CMDSIZE] = rx_cmdsize;
    int_set[INT_PKTEND]  = rx_pktend;
    int_set[INT_RXNE]    = ~rx_fifo_empty;
    int_set[INT_TXNF]    = ~tx_fifo_full;
    int_set[INT_TXWM]    = txwm_cond & ~txwm_cond_q;
    int_set[INT_RXWM]    = rxwm_cond & ~rxwm_cond_q;
    int_set[INT_FRMDONE] = frm_done;
    // Hardware set beats a same-cycle write-1-to-clear.
    raw_d = (raw_q & ~int_clr) | int_set;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ctrl1_q     <= '0;
      cmdsize_q   <= '0;
      en_lo_q     <= '0;
      en_hi_q     <= '0;
      ssel_q      <= '0;
      txwm_q      <= '0;
      rxwm_q      <= '0;
      clr_tx_q    <= 1'b0;
      clr_rx_q    <= 1'b0;
      txwm_cond_q <= 1'b0;
      rxwm_cond_q <= 1'b0;
      raw_q       <= '0;
`ifdef SPI_RF_FRAMECNT_EN
      frm_shadow_q <= '0;
      frm_cnt_q    <= '0;
`endif
    end else begin
      ctrl1_q     <= ctrl1_d;
      cmdsize_q   <= cmdsize_d;
      en_lo_q     <= en_lo_d;
      en_hi_q     <= en_hi_d;
      ssel_q      <= ssel_d;
      txwm_q      <= txwm_d;
      rxwm_q      <= rxwm_d;
      clr_tx_q    <= clr_tx_d;
      clr_rx_q    <= clr_rx_d;
      txwm_cond_q <= txwm_cond;
      rxwm_cond_q <= rxwm_cond;
      raw_q       <= raw_d;
`ifdef SPI_RF_FRAMECNT_EN
      frm_shadow_q <= frm_shadow_d;
      frm_cnt_q    <= frm_cnt_d;
`endif
    end
  end

  spi_rf_lvlcnt #(.FIFO_DEPTH(FIFO_DEPTH)) u_txlvl (
    .clk(pclk), .rst(preset), .inc(tx_fifo_write), .dec(tx_fifo_read), .clr(clr_tx_q), .level(tx_level)
  );

  spi_rf_lvlcnt #(.FIFO_DEPTH(FIFO_DEPTH)) u_rxlvl (
    .clk(pclk), .rst(preset), .inc(rx_fifo_write), .dec(rx_fifo_read), .clr(clr_rx_q), .level(rx_level)
  );

  // rx_done (bit 1) has no enable and never reaches the interrupt line.
  assign int_en     = {en_hi_q, en_lo_q, ctrl1_q[5], ctrl1_q[4], 1'b0, ctrl1_q[3]};
  assign int_masked = raw_q & int_en;
  assign interrupt  = |int_masked;

  always_comb begin
    rdata = '0;
    case (apb.paddr)
      ADDR_CTRL1:      rdata = ctrl1_q;
      ADDR_INTMASK_LO: rdata = int_masked[7:0];
      ADDR_INTMASK_HI: rdata = {5'b0, int_masked[10:8]};
      ADDR_INTRAW_LO:  rdata = raw_q[7:0];
      ADDR_INTRAW_HI:  rdata = {5'b0, raw_q[10:8]};
      ADDR_CTRL2:      rdata = {en_lo_q, 1'b0, cmdsize_q};
      ADDR_STATUS:     rdata = {active, ssel, raw_q[INT_TXUNF], raw_q[INT_RXOVF], tx_fifo_full,
                                rx_fifo_empty, raw_q[INT_TXDONE] & raw_q[INT_RXDONE], first_frame};
      ADDR_SSEL:       rdata = 8'(ssel_q);
      ADDR_TXLVL:      rdata = 8'(tx_level);
      ADDR_RXLVL:      rdata = 8'(rx_level);
      ADDR_TXWM:       rdata = txwm_q;
      ADDR_RXWM:       rdata = rxwm_q;
      ADDR_INTEN_HI:   rdata = {5'b0, en_hi_q};
`ifdef SPI_RF_FRAMECNT_EN
      ADDR_FRMCNT_LO:  rdata = frm_cnt_q[7:0];
      ADDR_FRMCNT_HI:  rdata = frm_cnt_q[15:8];
`endif
      default:         rdata = '0;
    endcase
  end

  assign apb.prdata = rd_en ? APB_DWIDTH'(rdata) : '0;

  assign cfg_enable    = ctrl1_q[0];
  assign cfg_master    = ctrl1_q[1];
  assign cfg_frameurun = ctrl1_q[6];
  assign cfg_oenoff    = ctrl1_q[7];
  assign cfg_cmdsize   = cmdsize_q;
  assign cfg_ssel      = ssel_q;
  assign clr_txfifo    = clr_tx_q;
  assign clr_rxfifo    = clr_rx_q;

endmodule

// File: tb/tb_spi_rf_ext.sv
// Self-checking bench for spi_rf_ext: 32-bit APB, 3 slave selects, depth-4 FIFO levels.
module tb_spi_rf_ext;
  import spi_rf_pkg::*;

  localparam int unsigned APB_DWIDTH = 32;
  localparam int unsigned NUM_SSEL   = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_rf_ext_if #(.APB_DWIDTH(APB_DWIDTH)) bus ();

  logic interrupt;
  logic tx_done, rx_done, rx_channel_overflow, tx_channel_underflow, rx_cmdsize, rx_pktend;
  logic tx_fifo_write, tx_fifo_read, rx_fifo_write, rx_fifo_read;
  logic tx_fifo_full, rx_fifo_empty, ssel, active, first_frame;
  logic cfg_enable, cfg_master, cfg_frameurun, cfg_oenoff;
  logic [2:0] cfg_cmdsize;
  logic [NUM_SSEL-1:0] cfg_ssel;
  logic clr_txfifo, clr_rxfifo;
  logic [LVL_W-1:0] tx_level, rx_level;

  spi_rf_ext #(.APB_DWIDTH(APB_DWIDTH), .NUM_SSEL(NUM_SSEL), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .pclk(clk), .preset(rst), .apb(bus), .interrupt(interrupt),
    .tx_done(tx_done), .rx_done(rx_done), .rx_channel_overflow(rx_channel_overflow),
    .tx_channel_underflow(tx_channel_underflow), .rx_cmdsize(rx_cmdsize), .rx_pktend(rx_pktend),
    .tx_fifo_write(tx_fifo_write), .tx_fifo_read(tx_fifo_read),
    .rx_fifo_write(rx_fifo_write), .rx_fifo_read(rx_fifo_read),
    .tx_fifo_full(tx_fifo_full), .rx_fifo_empty(rx_fifo_empty), .ssel(ssel), .active(active),
    .first_frame(first_frame), .cfg_enable(cfg_enable), .cfg_master(cfg_master),
    .cfg_frameurun(cfg_frameurun), .cfg_oenoff(cfg_oenoff), .cfg_cmdsize(cfg_cmdsize),
    .cfg_ssel(cfg_ssel), .clr_txfifo(clr_txfifo), .clr_rxfifo(clr_rxfifo),
    .tx_level(tx_level), .rx_level(rx_level)
  );

  logic [31:0] exp_q[$];
  logic [31:0] rd, e;
  int n_chk = 0;
  int n_fail = 0;

  task automatic apb_write(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.paddr = a; bus.pwdata = d; bus.pwrite = 1'b1; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [6:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.paddr = a; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    #1 d = bus.prdata;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] a;
    for (int i = 0; i < 20; i++) begin
      a = 7'(i * 4);
      exp_q.push_back(32'h0);
      apb_read(a, rd);
      e = exp_q.pop_front(); n_chk++;
      if (rd !== e) begin n_fail++; $display("FAIL reset_read[%h]: got %h expected %h", a, rd, e); end
    end
    n_chk++;
    if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", interrupt); end
    n_chk++;
    if ({clr_txfifo, clr_rxfifo, tx_level, rx_level} !== '0) begin
      n_fail++; $display("FAIL reset_lvl: got %b %b %0d %0d expected all 0", clr_txfifo, clr_rxfifo, tx_level, rx_level);
    end
    tx_fifo_full = 1'b1; rx_fifo_empty = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_txdone_irq();
    apb_write(ADDR_CTRL1, 32'h23);
    n_chk++;
    if ({cfg_enable, cfg_master} !== 2'b11) begin n_fail++; $display("FAIL ctrl1_cfg: got %b expected 11", {cfg_enable, cfg_master}); end
    @(negedge clk) tx_done = 1'b1;
    @(negedge clk) tx_done = 1'b0;
    exp_q.push_back(32'h01); exp_q.push_back(32'h00);
    apb_read(ADDR_INTRAW_LO, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL raw_txdone: got %h expected %h", rd, e); end
    apb_read(ADDR_INTMASK_LO, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL mask_txdone_off: got %h expected %h", rd, e); end
    n_chk++;
    if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_txdone_off: got %b expected 0", interrupt); end
    apb_write(ADDR_CTRL1, 32'h2B);
    exp_q.push_back(32'h01);
    apb_read(ADDR_INTMASK_LO, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL mask_txdone_on: got %h expected %h", rd, e); end
    n_chk++;
    if (interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_txdone_on: got %b expected 1", interrupt); end
    apb_write(ADDR_INTCLR_LO, 32'h01);
    exp_q.push_back(32'h00);
    apb_read(ADDR_INTRAW_LO, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL raw_cleared: got %h expected %h", rd, e); end
    // Clear write whose access cycle coincides with tx_done
    @(negedge clk);
    bus.paddr = ADDR_INTCLR_LO; bus.pwdata = 32'h01; bus.pwrite = 1'b1; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; tx_done = 1'b0;
    exp_q.push_back(32'h01);
    apb_read(ADDR_INTRAW_LO, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL set_beats_clear: got %h expected %h", rd, e); end
    apb_write(ADDR_INTCLR_LO, 32'h01);
    n_chk++;
    if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_after_clear: got %b expected 0", interrupt); end
  endtask

  task automatic test_levels();
    @(negedge clk) tx_fifo_write = 1'b1;
    repeat (5) @(negedge clk);
    tx_fifo_write = 1'b0;
    exp_q.push_back(32'h04);
    apb_read(ADDR_TXLVL, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL txlvl_sat: got %h expected %h", rd, e); end
    tx_fifo_write = 1'b1; tx_fifo_read = 1'b1;
    @(negedge clk) begin tx_fifo_write = 1'b0; tx_fifo_read = 1'b0; end
    n_chk++;
    if (tx_level !== 3'd4) begin n_fail++; $display("FAIL txlvl_wr_rd: got %0d expected 4", tx_level); end
    tx_fifo_read = 1'b1;
    @(negedge clk) tx_fifo_read = 1'b0;
    n_chk++;
    if (tx_level !== 3'd3) begin n_fail++; $display("FAIL txlvl_dec: got %0d expected 3", tx_level); end
    rx_fifo_read = 1'b1;
    @(negedge clk) rx_fifo_read = 1'b0;
    n_chk++;
    if (rx_level !== 3'd0) begin n_fail++; $display("FAIL rxlvl_floor: got %0d expected 0", rx_level); end
    apb_write(ADDR_CMD, 32'h02);
    n_chk++;
    if ({clr_txfifo, clr_rxfifo} !== 2'b10) begin n_fail++; $display("FAIL clr_strobe_on: got %b expected 10", {clr_txfifo, clr_rxfifo}); end
    tx_fifo_write = 1'b1;
    @(negedge clk) tx_fifo_write = 1'b0;
    n_chk++;
    if (clr_txfifo !== 1'b0) begin n_fail++; $display("FAIL clr_strobe_off: got %b expected 0", clr_txfifo); end
    exp_q.push_back(32'h00);
    apb_read(ADDR_TXLVL, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL txlvl_clr: got %h expected %h", rd, e); end
  endtask

  task automatic test_rx_watermark();
    apb_write(ADDR_RXWM, 32'h03);
    apb_write(ADDR_INTCLR_HI, 32'h02);
    apb_write(ADDR_INTEN_HI, 32'h02);
    exp_q.push_back(32'h01);
    apb_read(ADDR_INTRAW_HI, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL rxwm_idle: got %h expected %h", rd, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) rx_fifo_write = 1'b1;
      @(negedge clk) rx_fifo_write = 1'b0;
      exp_q.push_back(i == 2 ? 32'h03 : 32'h01);
      apb_read(ADDR_INTRAW_HI, rd);
      e = exp_q.pop_front(); n_chk++;
      if (rd !== e) begin n_fail++; $display("FAIL rxwm_push%0d: got %h expected %h", i + 1, rd, e); end
    end
    exp_q.push_back(32'h02);
    apb_read(ADDR_INTMASK_HI, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL rxwm_mask: got %h expected %h", rd, e); end
    n_chk++;
    if (interrupt !== 1'b1) begin n_fail++; $display("FAIL rxwm_irq: got %b expected 1", interrupt); end
    apb_write(ADDR_INTCLR_HI, 32'h02);
    @(negedge clk) rx_fifo_write = 1'b1;
    @(negedge clk) rx_fifo_write = 1'b0;
    exp_q.push_back(32'h01);
    apb_read(ADDR_INTRAW_HI, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL rxwm_no_retrigger: got %h expected %h", rd, e); end
    n_chk++;
    if (interrupt !== 1'b0) begin n_fail++; $display("FAIL rxwm_irq_off: got %b expected 0", interrupt); end
  endtask

  task automatic test_width_ssel();
    apb_write(ADDR_SSEL, 32'hFFFF_FFFF);
    apb_write(ADDR_CTRL2, 32'hFFFF_FFFF);
    apb_write(7'h08, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0007); exp_q.push_back(32'h0000_00F7); exp_q.push_back(32'h0);
    apb_read(ADDR_SSEL, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL ssel_read: got %h expected %h", rd, e); end
    apb_read(ADDR_CTRL2, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL ctrl2_read: got %h expected %h", rd, e); end
    apb_read(7'h08, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL unmapped_read: got %h expected %h", rd, e); end
    n_chk++;
    if ({cfg_ssel, cfg_cmdsize} !== 6'b111_111) begin n_fail++; $display("FAIL ssel_cmdsize_cfg: got %b expected 111111", {cfg_ssel, cfg_cmdsize}); end
    apb_write(ADDR_CTRL2, 32'h0);
    @(negedge clk);
    bus.paddr = ADDR_SSEL; bus.psel = 1'b1; bus.penable = 1'b0;
    #1;
    n_chk++;
    if (bus.prdata !== 32'h0) begin n_fail++; $display("FAIL prdata_setup_phase: got %h expected 0", bus.prdata); end
    @(negedge clk) bus.psel = 1'b0;
  endtask

  task automatic test_framecnt();
    apb_write(ADDR_FRMCNT_LO, 32'h02);
    apb_write(ADDR_FRMCNT_HI, 32'h00);
`ifdef SPI_RF_FRAMECNT_EN
    exp_q.push_back(32'h02);
`else
    exp_q.push_back(32'h00);
`endif
    apb_read(ADDR_FRMCNT_LO, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL frmcnt_load: got %h expected %h", rd, e); end
    repeat (2) begin
      @(negedge clk) tx_done = 1'b1;
      @(negedge clk) tx_done = 1'b0;
    end
    exp_q.push_back(32'h00);
`ifdef SPI_RF_FRAMECNT_EN
    exp_q.push_back(32'h05);
`else
    exp_q.push_back(32'h01);
`endif
    apb_read(ADDR_FRMCNT_LO, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL frmcnt_zero: got %h expected %h", rd, e); end
    apb_read(ADDR_INTRAW_HI, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL frmdone_raw: got %h expected %h", rd, e); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk) tx_fifo_write = 1'b1;
    @(negedge clk) tx_fifo_write = 1'b0;
    apb_write(ADDR_CMD, 32'h01);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({clr_rxfifo, clr_txfifo, cfg_enable, tx_level} !== '0) begin
      n_fail++; $display("FAIL midflight_reset: got %b %b %b %0d expected all 0", clr_rxfifo, clr_txfifo, cfg_enable, tx_level);
    end
    exp_q.push_back(32'h0);
    apb_read(ADDR_CTRL1, rd);
    e = exp_q.pop_front(); n_chk++;
    if (rd !== e) begin n_fail++; $display("FAIL midflight_ctrl1: got %h expected %h", rd, e); end
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.paddr = '0; bus.psel = 1'b0; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.pwdata = '0;
    {tx_done, rx_done, rx_channel_overflow, tx_channel_underflow, rx_cmdsize, rx_pktend} = '0;
    {tx_fifo_write, tx_fifo_read, rx_fifo_write, rx_fifo_read} = '0;
    {tx_fifo_full, rx_fifo_empty, ssel, active, first_frame} = '0;
    repeat (2) @(negedge clk);
    test_reset();
    repeat (2) @(negedge clk);
    test_txdone_irq();
    test_levels();
    test_rx_watermark();
    test_width_ssel();
    test_framecnt();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
